hp_fifo: RTL

HP_FIFO -- requirements
Module: hp_fifo

---
 rtl/hp_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/hp_fifo.sv
// Host-to-parasite dual-clock FIFO; pointers cross as Gray through two falling-edge flops (2-3 edge visibility).
// Host writes are dropped while h_full; parasite pops only when data is available, so neither side can overrun.
module hp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             h_phi2,
  input  logic             h_rst_b,
  input  logic             p_phi2,
  input  logic             h_selectData,
  input  logic             h_we_b,
  input  logic [WIDTH-1:0] h_data,
  input  logic             h_mode,
  input  logic             p_selectData,
  input  logic             p_rdnw,
  input  logic             p_irq_en,
  output logic [WIDTH-1:0] p_data,
  output logic             p_data_available,
  output logic             p_irq,
  output logic             h_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  ptr_t wptr_q, wptr_d, wgray_q, wgray_d;
  ptr_t h_rsync1_q, h_rsync1_d, h_rsync2_q, h_rsync2_d;
  ptr_t rptr_q, rptr_d, rgray_q, rgray_d;
  ptr_t p_wsync1_q, p_wsync1_d, p_wsync2_q, p_wsync2_d;
  ptr_t h_occ;
  logic h_push, p_pop;

  // Host side: own writes count immediately, parasite pops only once synchronised.
  always_comb begin
    h_occ      = wptr_q - gray2bin(h_rsync2_q);
    h_full     = h_mode ? (h_occ == PW'(DEPTH)) : (h_occ != '0);
    h_push     = h_selectData && !h_we_b && !h_full;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    if (h_push) begin
      mem_d[wptr_q[AW-1:0]] = h_data;
      wptr_d                = wptr_q + PW'(1);
    end
    wgray_d    = bin2gray(wptr_d);
    h_rsync1_d = rgray_q;
    h_rsync2_d = h_rsync1_q;
  end

  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      wgray_q    <= '0;
      h_rsync1_q <= '0;
      h_rsync2_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      wgray_q    <= wgray_d;
      h_rsync1_q <= h_rsync1_d;
      h_rsync2_q <= h_rsync2_d;
    end
  end

  always_comb begin
    p_data_available = (gray2bin(p_wsync2_q) != rptr_q);
    p_irq            = p_data_available && p_irq_en;
    p_data           = mem_q[rptr_q[AW-1:0]];
    p_pop            = p_selectData && p_rdnw && p_data_available;
    rptr_d           = p_pop ? rptr_q + PW'(1) : rptr_q;
    rgray_d          = bin2gray(rptr_d);
    p_wsync1_d       = wgray_q;
    p_wsync2_d       = p_wsync1_q;
  end

  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rptr_q     <= '0;
      rgray_q    <= '0;
      p_wsync1_q <= '0;
      p_wsync2_q <= '0;
    end else begin
      rptr_q     <= rptr_d;
      rgray_q    <= rgray_d;
      p_wsync1_q <= p_wsync1_d;
      p_wsync2_q <= p_wsync2_d;
    end
  end

endmodule
